// File: rtl/soc_wb_tile_arbiter_pkg.sv
// Shared types and constants for the tile-local Wishbone arbiter and its users.
package soc_wb_tile_arbiter_pkg;

  typedef enum logic [1:0] {
    REGION_LOCAL = 2'd0,
    REGION_DM    = 2'd1,
    REGION_PGAS  = 2'd2
  } wb_region_t;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_BUSY  = 2'd1,
    ARB_ABORT = 2'd2
  } arb_state_t;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_END     = 3'b111;

endpackage

// File: rtl/soc_wb_tile_arbiter_if.sv
// Wishbone B3 bundle for N ports sharing one broadcast read-data bus.
interface soc_wb_tile_arbiter_if #(
  parameter int unsigned N  = 1,
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
);
  logic [N*AW-1:0]     adr;
  logic [N*DW-1:0]     dat_w;
  logic [N*DW/8-1:0]   sel;
  logic [N-1:0]        we;
  logic [N-1:0]        cyc;
  logic [N-1:0]        stb;
  logic [N*3-1:0]      cti;
  logic [N*2-1:0]      bte;
  logic [DW-1:0]       dat_r;
  logic [N-1:0]        ack;
  logic [N-1:0]        err;

  modport master (
    output adr, dat_w, sel, we, cyc, stb, cti, bte,
    input  dat_r, ack, err
  );

  modport slave (
    input  adr, dat_w, sel, we, cyc, stb, cti, bte,
    output dat_r, ack, err
  );
endinterface

// File: rtl/soc_wb_tile_arbiter_rr.sv
// Combinational round-robin pick: first request at or after ptr_i, wrapping.
module soc_rr_arbiter #(
  parameter int unsigned N  = 3,
  parameter int unsigned PW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  grant_o
);

  always_comb begin
    logic [PW:0]   sum;
    logic [PW-1:0] idx;
    logic          found;
    grant_o = '0;
    found   = 1'b0;
    sum     = '0;
    idx     = '0;
    for (int unsigned i = 0; i < N; i++) begin
      sum = {1'b0, ptr_i} + (PW+1)'(i);
      if (sum >= (PW+1)'(N)) sum = sum - (PW+1)'(N);
      idx = sum[PW-1:0];
      if (!found && req_i[idx]) begin
        grant_o[idx] = 1'b1;
        found        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/soc_wb_tile_arbiter.sv
// Round-robin Wishbone arbiter holding the grant for a full cyc tenure, with
// stall timeout and DM/PGAS region classification of the granted address.
module soc_wb_tile_arbiter
  import soc_wb_tile_arbiter_pkg::*;
#(
  parameter int unsigned MASTERS          = 3,
  parameter int unsigned AW               = 32,
  parameter int unsigned DW               = 32,
  parameter int unsigned TIMEOUT          = 255,
  parameter int unsigned ENABLE_DM        = 1,
  parameter int unsigned DM_RANGE_WIDTH   = 1,
  parameter int unsigned DM_RANGE_MATCH   = 0,
  parameter int unsigned ENABLE_PGAS      = 0,
  parameter int unsigned PGAS_RANGE_WIDTH = 1,
  parameter int unsigned PGAS_RANGE_MATCH = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  soc_wb_tile_arbiter_if.slave  m,
  soc_wb_tile_arbiter_if.master s,
  output logic [1:0]           s_region_o,
  output logic [MASTERS-1:0]   grant_o
);

  localparam int unsigned PW = $clog2(MASTERS);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam int unsigned SW = DW / 8;

  arb_state_t         state_q, state_d;
  logic [MASTERS-1:0] grant_q, grant_d, rr_grant;
  logic [PW-1:0]      ptr_q, ptr_d, gidx;
  logic [TW-1:0]      cnt_q, cnt_d;
  logic               g_cyc, stall, expire;
  logic               dm_hit, pgas_hit;
  wb_region_t         region;

  soc_rr_arbiter #(.N(MASTERS), .PW(PW)) u_rr (
    .req_i   (m.cyc),
    .ptr_i   (ptr_q),
    .grant_o (rr_grant)
  );

  always_comb begin
    gidx = '0;
    for (int unsigned i = 0; i < MASTERS; i++) begin
      if (grant_q[i]) gidx = PW'(i);
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    cnt_d   = '0;
    stall   = 1'b0;
    expire  = 1'b0;
    g_cyc   = m.cyc[gidx];
    s.adr   = '0;
    s.dat_w = '0;
    s.sel   = '0;
    s.we    = '0;
    s.cyc   = '0;
    s.stb   = '0;
    s.cti   = '0;
    s.bte   = '0;
    m.ack   = '0;
    m.err   = '0;
    m.dat_r = s.dat_r;

    case (state_q)
      ARB_IDLE: begin
        if (|m.cyc) begin
          grant_d = rr_grant;
          state_d = ARB_BUSY;
        end
      end
      ARB_BUSY, ARB_ABORT: begin
        s.adr   = m.adr[gidx*AW +: AW];
        s.dat_w = m.dat_w[gidx*DW +: DW];
        s.sel   = m.sel[gidx*SW +: SW];
        s.we    = m.we[gidx];
        s.cti   = m.cti[gidx*3 +: 3];
        s.bte   = m.bte[gidx*2 +: 2];
        if (state_q == ARB_BUSY) begin
          s.cyc  = m.cyc[gidx];
          s.stb  = m.stb[gidx];
          stall  = m.stb[gidx] & ~s.ack[0] & ~s.err[0];
          // An ack in the expiry cycle clears stall, so it wins over the abort.
          expire = g_cyc && stall && (cnt_q == TW'(TIMEOUT));
          m.ack  = grant_q & {MASTERS{s.ack[0]}};
          m.err  = grant_q & {MASTERS{s.err[0] | expire}};
        end
        if (!g_cyc) begin
          grant_d = '0;
          state_d = ARB_IDLE;
          ptr_d   = (gidx == PW'(MASTERS - 1)) ? '0 : gidx + PW'(1);
        end else if (expire) begin
          state_d = ARB_ABORT;
        end else if (stall) begin
          cnt_d = cnt_q + TW'(1);
        end
      end
      default: begin
        state_d = ARB_IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ARB_IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign dm_hit   = (ENABLE_DM != 0) &&
                    (s.adr[AW-1 -: DM_RANGE_WIDTH] == DM_RANGE_WIDTH'(DM_RANGE_MATCH));
  assign pgas_hit = (ENABLE_PGAS != 0) &&
                    (s.adr[AW-1 -: PGAS_RANGE_WIDTH] == PGAS_RANGE_WIDTH'(PGAS_RANGE_MATCH));

  always_comb begin
    region = REGION_LOCAL;
    if (state_q != ARB_IDLE) begin
      if (dm_hit)        region = REGION_DM;
      else if (pgas_hit) region = REGION_PGAS;
    end
  end

  assign s_region_o = region;
  assign grant_o    = grant_q;

endmodule

// File: tb/tb_soc_wb_tile_arbiter.sv
// Scenario bench for soc_wb_tile_arbiter with a round-robin/region reference model.
module tb_soc_wb_tile_arbiter;
  import soc_wb_tile_arbiter_pkg::*;

  localparam int unsigned NM  = 3;
  localparam int unsigned AW  = 32;
  localparam int unsigned DW  = 32;
  localparam int unsigned TMO = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [1:0]    s_region;
  logic [NM-1:0] grant;
  int            total = 0;
  int            bad = 0;
  int            ptr_m = 0;

  soc_wb_tile_arbiter_if #(.N(NM), .AW(AW), .DW(DW)) mbus ();
  soc_wb_tile_arbiter_if #(.N(1),  .AW(AW), .DW(DW)) sbus ();

  soc_wb_tile_arbiter #(
    .MASTERS(NM), .AW(AW), .DW(DW), .TIMEOUT(TMO),
    .ENABLE_DM(1), .DM_RANGE_WIDTH(1), .DM_RANGE_MATCH(1),
    .ENABLE_PGAS(1), .PGAS_RANGE_WIDTH(4), .PGAS_RANGE_MATCH(4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .m          (mbus.slave),
    .s          (sbus.master),
    .s_region_o (s_region),
    .grant_o    (grant)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- reference model ----------------
  function automatic int pick(input logic [NM-1:0] req);
    for (int i = 0; i < NM; i++) begin
      int idx;
      idx = (ptr_m + i) % NM;
      if (req[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic logic [NM-1:0] oh(input int k);
    logic [NM-1:0] r;
    r = '0;
    r[k] = 1'b1;
    return r;
  endfunction

  function automatic logic [1:0] region_of(input logic [31:0] a);
    logic [3:0] top;
    top = a[31:28];
    if (a[31]) return 2'd1;
    if (top == 4'd4) return 2'd2;
    return 2'd0;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic drive_m(input int k, input logic c, input logic st, input logic [31:0] a,
                         input logic [31:0] d, input logic w, input logic [2:0] cti);
    mbus.cyc[k]              = c;
    mbus.stb[k]              = st;
    mbus.adr[k*AW +: AW]     = a;
    mbus.dat_w[k*DW +: DW]   = d;
    mbus.we[k]               = w;
    mbus.sel[k*4 +: 4]       = 4'hF;
    mbus.cti[k*3 +: 3]       = cti;
    mbus.bte[k*2 +: 2]       = 2'b00;
  endtask

  task automatic idle_all();
    for (int k = 0; k < NM; k++) drive_m(k, 1'b0, 1'b0, '0, '0, 1'b0, CTI_CLASSIC);
    sbus.ack   = '0;
    sbus.err   = '0;
    sbus.dat_r = '0;
  endtask

  task automatic respond(input int lat, input logic [31:0] rd);
    repeat (lat) step();
    sbus.ack   = 1'b1;
    sbus.dat_r = rd;
    settle();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    idle_all();
    rst_n = 1'b0;
    repeat (3) step();
    settle();
    total++; if (grant !== '0) begin bad++; $display("FAIL reset_grant: got %b want 0", grant); end
    total++; if (sbus.cyc !== 1'b0) begin bad++; $display("FAIL reset_s_cyc: got %b want 0", sbus.cyc); end
    total++; if (sbus.stb !== 1'b0) begin bad++; $display("FAIL reset_s_stb: got %b want 0", sbus.stb); end
    total++; if (sbus.adr !== '0) begin bad++; $display("FAIL reset_s_adr: got %h want 0", sbus.adr); end
    total++; if (mbus.ack !== '0) begin bad++; $display("FAIL reset_m_ack: got %b want 0", mbus.ack); end
    total++; if (mbus.err !== '0) begin bad++; $display("FAIL reset_m_err: got %b want 0", mbus.err); end
    total++; if (s_region !== 2'd0) begin bad++; $display("FAIL reset_region: got %0d want 0", s_region); end
    step();
    rst_n = 1'b1;
    ptr_m = 0;
    step();
  endtask

  task automatic test_single();
    for (int it = 0; it < 7; it++) begin
      int k, lat;
      logic [31:0] a, wd, rd;
      logic w;
      k   = (it == 0) ? 1 : int'($urandom_range(0, NM-1));
      a   = (it == 0) ? 32'h0000_0100 : $urandom;
      lat = (it == 0) ? 2 : int'($urandom_range(0, 3));
      w   = (it == 0) ? 1'b0 : 1'($urandom_range(0, 1));
      wd  = $urandom;
      rd  = $urandom;
      step();
      drive_m(k, 1'b1, 1'b1, a, wd, w, CTI_CLASSIC);
      settle();
      total++; if (grant !== '0) begin bad++; $display("FAIL single_latency: got %b want 0", grant); end
      step();
      settle();
      total++; if (grant !== oh(k)) begin bad++; $display("FAIL single_grant: got %b want %b", grant, oh(k)); end
      total++; if (sbus.cyc !== 1'b1) begin bad++; $display("FAIL single_s_cyc: got %b want 1", sbus.cyc); end
      total++; if (sbus.adr !== a) begin bad++; $display("FAIL single_s_adr: got %h want %h", sbus.adr, a); end
      total++; if (sbus.dat_w !== wd || sbus.we !== w) begin bad++; $display("FAIL single_s_wdata: got %h/%b want %h/%b", sbus.dat_w, sbus.we, wd, w); end
      total++; if (s_region !== region_of(a)) begin bad++; $display("FAIL single_region: got %0d want %0d", s_region, region_of(a)); end
      respond(lat, rd);
      total++; if (mbus.ack !== oh(k)) begin bad++; $display("FAIL single_ack: got %b want %b", mbus.ack, oh(k)); end
      total++; if (mbus.dat_r !== rd) begin bad++; $display("FAIL single_rdata: got %h want %h", mbus.dat_r, rd); end
      step();
      sbus.ack = 1'b0;
      drive_m(k, 1'b0, 1'b0, a, wd, w, CTI_CLASSIC);
      settle();
      total++; if (grant !== oh(k) || mbus.ack !== '0) begin bad++; $display("FAIL single_hold: got %b/%b want %b/0", grant, mbus.ack, oh(k)); end
      step();
      settle();
      ptr_m = (k + 1) % NM;
      total++; if (grant !== '0 || sbus.cyc !== 1'b0) begin bad++; $display("FAIL single_release: got %b/%b want 0/0", grant, sbus.cyc); end
    end
  endtask

  task automatic test_random_arb();
    for (int it = 0; it < 12; it++) begin
      logic [NM-1:0] req;
      logic [31:0]   a[NM];
      logic [31:0]   d[NM];
      int w;
      req = NM'($urandom_range(1, (1 << NM) - 1));
      step();
      for (int k = 0; k < NM; k++) begin
        a[k] = $urandom;
        d[k] = $urandom;
        drive_m(k, req[k], req[k], a[k], d[k], 1'b1, CTI_CLASSIC);
      end
      w = pick(req);
      step();
      settle();
      total++; if (grant !== oh(w)) begin bad++; $display("FAIL rr_grant: req %b got %b want %b", req, grant, oh(w)); end
      total++; if (sbus.adr !== a[w] || sbus.dat_w !== d[w]) begin bad++; $display("FAIL rr_mux: got %h/%h want %h/%h", sbus.adr, sbus.dat_w, a[w], d[w]); end
      respond(int'($urandom_range(0, 2)), $urandom);
      total++; if (mbus.ack !== oh(w)) begin bad++; $display("FAIL rr_ack: got %b want %b", mbus.ack, oh(w)); end
      step();
      idle_all();
      step();
      settle();
      ptr_m = (w + 1) % NM;
      total++; if (grant !== '0) begin bad++; $display("FAIL rr_release: got %b want 0", grant); end
    end
  endtask

  task automatic test_fairness();
    int w;
    step();
    for (int k = 0; k < NM; k++) drive_m(k, 1'b1, 1'b1, 32'h100 * k, '0, 1'b0, CTI_CLASSIC);
    w = pick(3'b111);
    step();
    settle();
    total++; if (grant !== oh(w)) begin bad++; $display("FAIL fair_grant0: got %b want %b", grant, oh(w)); end
    for (int t = 0; t < 6; t++) begin
      logic [31:0] rd;
      rd = $urandom;
      respond(int'($urandom_range(0, 3)), rd);
      total++; if (mbus.ack !== oh(w) || mbus.dat_r !== rd) begin bad++; $display("FAIL fair_ack: got %b/%h want %b/%h", mbus.ack, mbus.dat_r, oh(w), rd); end
      step();
      sbus.ack = 1'b0;
      drive_m(w, 1'b0, 1'b0, 32'h100 * w, '0, 1'b0, CTI_CLASSIC);
      step();
      ptr_m = (w + 1) % NM;
      if (t < 5) drive_m(w, 1'b1, 1'b1, 32'h100 * w, '0, 1'b0, CTI_CLASSIC);
      else idle_all();
      settle();
      total++; if (grant !== '0) begin bad++; $display("FAIL fair_gap: got %b want 0", grant); end
      if (t < 5) begin
        step();
        settle();
        w = pick(3'b111);
        total++; if (grant !== oh(w)) begin bad++; $display("FAIL fair_grant: got %b want %b", grant, oh(w)); end
      end
    end
    step();
  endtask

  task automatic test_burst_lock();
    logic [31:0] base;
    base = {$urandom_range(0, 32'h3FFF_FFFF)} & 32'hFFFF_FFF0;
    step();
    drive_m(0, 1'b1, 1'b1, base, '0, 1'b0, CTI_INCR);
    step();
    drive_m(2, 1'b1, 1'b1, 32'h0000_2000, '0, 1'b0, CTI_CLASSIC);
    settle();
    total++; if (grant !== 3'b001) begin bad++; $display("FAIL burst_grant: got %b want 001", grant); end
    for (int b = 0; b < 4; b++) begin
      logic [31:0] a;
      a = base + 32'(4 * b);
      if (b > 0) begin
        drive_m(0, 1'b1, 1'b1, a, '0, 1'b0, (b == 3) ? CTI_END : CTI_INCR);
        settle();
      end
      total++; if (sbus.adr !== a || grant !== 3'b001) begin bad++; $display("FAIL burst_beat_adr: got %h/%b want %h/001", sbus.adr, grant, a); end
      respond(int'($urandom_range(0, 2)), $urandom);
      total++; if (mbus.ack !== 3'b001) begin bad++; $display("FAIL burst_ack: got %b want 001", mbus.ack); end
      step();
      sbus.ack = 1'b0;
    end
    drive_m(0, 1'b0, 1'b0, base, '0, 1'b0, CTI_CLASSIC);
    settle();
    total++; if (grant !== 3'b001) begin bad++; $display("FAIL burst_hold: got %b want 001", grant); end
    step();
    settle();
    ptr_m = 1;
    total++; if (grant !== '0) begin bad++; $display("FAIL burst_gap: got %b want 0", grant); end
    step();
    settle();
    total++; if (grant !== oh(pick(3'b100))) begin bad++; $display("FAIL burst_next: got %b want %b", grant, oh(pick(3'b100))); end
    respond(0, $urandom);
    total++; if (mbus.ack !== 3'b100) begin bad++; $display("FAIL burst_next_ack: got %b want 100", mbus.ack); end
    step();
    idle_all();
    step();
    ptr_m = 0;
    step();
  endtask

  task automatic test_timeout();
    int k, j;
    logic [NM-1:0] err_early;
    logic [31:0] rd;
    k = int'($urandom_range(0, NM-1));
    j = (k + 1 + int'($urandom_range(0, 1))) % NM;
    err_early = '0;
    step();
    drive_m(k, 1'b1, 1'b1, 32'h0000_0040, '0, 1'b0, CTI_CLASSIC);
    step();
    drive_m(j, 1'b1, 1'b1, 32'h0000_0080, '0, 1'b0, CTI_CLASSIC);
    settle();
    total++; if (grant !== oh(k)) begin bad++; $display("FAIL tmo_grant: got %b want %b", grant, oh(k)); end
    for (int c = 1; c <= int'(TMO) + 1; c++) begin
      if (c > 1) begin
        step();
        settle();
      end
      if (c <= int'(TMO)) err_early = err_early | mbus.err | mbus.ack;
    end
    total++; if (err_early !== '0) begin bad++; $display("FAIL tmo_early: got %b want 0", err_early); end
    total++; if (mbus.err !== oh(k)) begin bad++; $display("FAIL tmo_err: got %b want %b", mbus.err, oh(k)); end
    step();
    settle();
    total++; if (mbus.err !== '0) begin bad++; $display("FAIL tmo_err_pulse: got %b want 0", mbus.err); end
    total++; if (sbus.cyc !== 1'b0 || sbus.stb !== 1'b0) begin bad++; $display("FAIL tmo_abort_bus: got %b/%b want 0/0", sbus.cyc, sbus.stb); end
    total++; if (grant !== oh(k)) begin bad++; $display("FAIL tmo_abort_hold: got %b want %b", grant, oh(k)); end
    step();
    drive_m(k, 1'b0, 1'b0, '0, '0, 1'b0, CTI_CLASSIC);
    step();
    settle();
    ptr_m = (k + 1) % NM;
    total++; if (grant !== '0) begin bad++; $display("FAIL tmo_release: got %b want 0", grant); end
    step();
    settle();
    total++; if (grant !== oh(pick(oh(j)))) begin bad++; $display("FAIL tmo_next: got %b want %b", grant, oh(j)); end
    rd = $urandom;
    respond(1, rd);
    total++; if (mbus.ack !== oh(j) || mbus.dat_r !== rd) begin bad++; $display("FAIL tmo_next_ack: got %b/%h want %b/%h", mbus.ack, mbus.dat_r, oh(j), rd); end
    step();
    idle_all();
    step();
    ptr_m = (j + 1) % NM;
    step();
  endtask

  task automatic test_timeout_ack_race();
    int k;
    logic [31:0] rd;
    k  = int'($urandom_range(0, NM-1));
    rd = $urandom;
    step();
    drive_m(k, 1'b1, 1'b1, 32'h0000_0200, '0, 1'b0, CTI_CLASSIC);
    step();
    settle();
    for (int c = 2; c <= int'(TMO) + 1; c++) begin
      step();
      if (c == int'(TMO) + 1) begin
        sbus.ack   = 1'b1;
        sbus.dat_r = rd;
      end
      settle();
    end
    total++; if (mbus.ack !== oh(k) || mbus.err !== '0) begin bad++; $display("FAIL race_ack_wins: got ack %b err %b want %b/0", mbus.ack, mbus.err, oh(k)); end
    step();
    sbus.ack = 1'b0;
    settle();
    total++; if (sbus.cyc !== 1'b1 || mbus.err !== '0) begin bad++; $display("FAIL race_no_abort: got cyc %b err %b want 1/0", sbus.cyc, mbus.err); end
    step();
    idle_all();
    step();
    ptr_m = (k + 1) % NM;
    step();
  endtask

  task automatic test_drop_with_ack();
    int k;
    k = int'($urandom_range(0, NM-1));
    step();
    drive_m(k, 1'b1, 1'b1, 32'h0000_0300, '0, 1'b0, CTI_INCR);
    step();
    step();
    drive_m(k, 1'b0, 1'b0, 32'h0000_0300, '0, 1'b0, CTI_INCR);
    sbus.ack = 1'b1;
    settle();
    total++; if (mbus.ack !== oh(k)) begin bad++; $display("FAIL drop_ack_fwd: got %b want %b", mbus.ack, oh(k)); end
    step();
    sbus.ack = 1'b0;
    settle();
    ptr_m = (k + 1) % NM;
    total++; if (grant !== '0) begin bad++; $display("FAIL drop_release: got %b want 0", grant); end
    step();
  endtask

  task automatic test_region();
    int k;
    logic [31:0] addrs[7];
    k = int'($urandom_range(0, NM-1));
    addrs[0] = 32'h8000_0000;
    addrs[1] = 32'h0000_0000;
    addrs[2] = 32'h4000_0000;
    for (int i = 3; i < 7; i++) addrs[i] = $urandom;
    step();
    drive_m(k, 1'b1, 1'b0, addrs[0], '0, 1'b0, CTI_CLASSIC);
    step();
    for (int i = 0; i < 7; i++) begin
      drive_m(k, 1'b1, 1'b0, addrs[i], '0, 1'b0, CTI_CLASSIC);
      settle();
      total++; if (sbus.adr !== addrs[i] || s_region !== region_of(addrs[i])) begin bad++; $display("FAIL region_decode: adr %h got %0d want %0d", addrs[i], s_region, region_of(addrs[i])); end
      step();
    end
    drive_m(k, 1'b0, 1'b0, 32'h8000_0000, '0, 1'b0, CTI_CLASSIC);
    step();
    settle();
    ptr_m = (k + 1) % NM;
    total++; if (s_region !== 2'd0 || grant !== '0) begin bad++; $display("FAIL region_idle: got %0d/%b want 0/0", s_region, grant); end
    idle_all();
    step();
  endtask

  task automatic test_reset_mid_burst();
    step();
    drive_m(0, 1'b1, 1'b1, 32'h0000_0010, '0, 1'b0, CTI_CLASSIC);
    step();
    respond(0, $urandom);
    step();
    idle_all();
    step();
    ptr_m = 1;
    drive_m(2, 1'b1, 1'b1, 32'h0000_0400, '0, 1'b0, CTI_INCR);
    step();
    settle();
    total++; if (grant !== oh(pick(3'b100))) begin bad++; $display("FAIL rstb_grant: got %b want 100", grant); end
    sbus.ack = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    ptr_m = 0;
    total++; if (grant !== '0 || sbus.cyc !== 1'b0 || mbus.ack !== '0) begin bad++; $display("FAIL rstb_async: got grant %b cyc %b ack %b want 0/0/0", grant, sbus.cyc, mbus.ack); end
    idle_all();
    step();
    rst_n = 1'b1;
    step();
    drive_m(0, 1'b1, 1'b1, 32'h0000_0500, '0, 1'b0, CTI_CLASSIC);
    drive_m(1, 1'b1, 1'b1, 32'h0000_0600, '0, 1'b0, CTI_CLASSIC);
    step();
    settle();
    total++; if (grant !== oh(pick(3'b011))) begin bad++; $display("FAIL rstb_ptr: got %b want %b", grant, oh(pick(3'b011))); end
    step();
    idle_all();
    step();
  endtask

  initial begin
    idle_all();
    test_reset();
    test_single();
    test_random_arb();
    test_fairness();
    test_burst_lock();
    test_timeout();
    test_timeout_ack_race();
    test_drop_with_ack();
    test_region();
    test_reset_mid_burst();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
